vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Transaction controller for the coin vending datapath.
- Accumulates coin credit and accepts a product selection.
- Drives the product dispense mechanism and the change hopper through req/ack handshakes.
- Sits between the coin acceptor/keypad and the dispense/hopper actuators.
- Credit is counted in 5-rupee units.

Parameters:
- PRICE0, 3, price of product 0 in 5-rupee units (15 Rs)
- PRICE1, 4, price of product 1 (20 Rs)
- PRICE2, 5, price of product 2 (25 Rs)
- PRICE3, 6, price of product 3 (30 Rs)
- MAX_CREDIT, 10, credit ceiling in units (50 Rs); must be ≤15
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before auto-refund; must be ≥2 and <65536

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- coin_valid  in  1  one-cycle strobe, coin present on coin_in
- coin_in  in  2  01=5 Rs, 10=10 Rs, 11=15 Rs, 00=no coin (ignored even with coin_valid)
- sel_valid  in  1  one-cycle strobe, product selection on sel_id
- sel_id  in  2  product index 0..3
- cancel  in  1  one-cycle strobe, refund request
- vend_ack  in  1  dispense mechanism done
- change_ack  in  1  hopper paid out one 5-Rs coin
- vend_req  out  1  dispense request, held until vend_ack
- vend_id  out  2  product being dispensed, stable while vend_req=1
- change_req  out  1  hopper payout request, held while credit>0 in CHANGE
- credit  out  4  current credit in units
- coin_reject  out  1  one-cycle pulse, coin returned uncounted
- sel_nak  out  1  one-cycle pulse, selection refused (insufficient credit)
- busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. rst dominates every other input.
- All outputs are registered. Each response appears the cycle after its causing input.
- coin value v = coin_in (1, 2 or 3 units).
- IDLE:
  - coin_valid with v≠0 -> credit=v, go to CREDIT.
  - sel_valid -> sel_nak pulse.
  - cancel ignored.
- CREDIT:
  - coin_valid, v≠0, credit+v ≤ MAX_CREDIT -> credit+=v, timeout counter cleared.
  - coin_valid, v≠0, credit+v > MAX_CREDIT -> coin_reject pulse, credit unchanged.
  - sel_valid, credit ≥ PRICE[sel_id] -> credit-=PRICE, vend_id=sel_id, vend_req=1, go to VEND.
  - sel_valid, credit < price -> sel_nak pulse, stay, timeout counter cleared.
  - cancel -> go to CHANGE.
  - Timeout counter increments each cycle with no coin/sel/cancel strobe. Reaching TIMEOUT_CYC-1 -> go to CHANGE.
  - Priority in the same cycle: cancel > sel_valid > coin_valid. A coin lost to a higher-priority strobe gets a coin_reject pulse.
- VEND:
  - vend_req held until the cycle vend_ack=1.
  - Next cycle: vend_req=0, then go to CHANGE if credit>0, else IDLE.
- CHANGE:
  - change_req=1 while credit>0.
  - Each cycle with change_ack=1 -> credit-=1.
  - The ack that brings credit to 0 also drops change_req and returns to IDLE next cycle.
  - change_ack when credit=0 is ignored; credit never underflows.
- In VEND/CHANGE, coin_valid (v≠0) -> coin_reject pulse. sel_valid -> sel_nak. cancel ignored.
- vend_ack outside VEND is ignored. change_ack outside CHANGE is ignored.
- A single transaction yields at most one vend.
- Arithmetic is 4-bit unsigned. The MAX_CREDIT check is done at 5 bits so it cannot wrap.

Optional Feature:
- Macro: MULTI_VEND_EN.
- Defined: after vend_ack with credit>0, return to CREDIT (timeout counter cleared) instead of CHANGE. Further selections are allowed; cancel/timeout refund the remainder.
- Undefined: remainder is always refunded via CHANGE as described above.

Test Plan:
- Coins 10 Rs + 5 Rs, sel_id=0 -> vend_req=1, vend_id=0, credit=0; vend_ack -> IDLE, change_req never asserted.
- Coins 15+15 Rs, sel_id=1 -> credit 6->2, vend. After vend_ack, change_req high for exactly 2 change_acks, then IDLE, credit=0.
- Coin 5 Rs, sel_id=3 -> sel_nak pulse, credit stays 1. Then cancel -> one change_ack returns to IDLE.
- Credit 9, insert 10 Rs -> coin_reject pulse, credit 9. Insert 5 Rs -> credit 10.
- Coin 5 Rs, then no strobes for TIMEOUT_CYC cycles -> CHANGE with change_req=1. Coin during CHANGE -> coin_reject.
- rst asserted in VEND with vend_req=1 -> next cycle all outputs 0, IDLE. Late vend_ack is ignored.

Source files
------------

// File: rtl/vend_sequencer.sv
// Coin vending transaction controller: credit accumulation, selection, dispense and change handshakes.
// Optional macro MULTI_VEND_EN: after a dispense with credit left over, return to CREDIT instead of refunding.
module vend_sequencer #(
  parameter int unsigned PRICE0      = 3,
  parameter int unsigned PRICE1      = 4,
  parameter int unsigned PRICE2      = 5,
  parameter int unsigned PRICE3      = 6,
  parameter int unsigned MAX_CREDIT  = 10,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_in,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       change_ack,
  output logic       vend_req,
  output logic [1:0] vend_id,
  output logic       change_req,
  output logic [3:0] credit,
  output logic       coin_reject,
  output logic       sel_nak,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_credit;
  logic [TW-1:0] r_tcnt;
  logic          r_vend_req;
  logic [1:0]    r_vend_id;
  logic          r_change_req;
  logic          r_coin_reject;
  logic          r_sel_nak;
  logic          r_busy;

  state_t        w_state_nx;
  logic [CW-1:0] w_credit_nx;
  logic [TW-1:0] w_tcnt_nx;
  logic          w_vend_req_nx;
  logic [1:0]    w_vend_id_nx;
  logic          w_change_req_nx;
  logic          w_coin_reject_nx;
  logic          w_sel_nak_nx;
  logic          w_busy_nx;
  logic          w_coin;
  logic [CW-1:0] w_price;
  logic [CW:0]   w_sum;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_tcnt        <= '0;
      r_vend_req    <= 1'b0;
      r_vend_id     <= '0;
      r_change_req  <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_nak     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_credit      <= w_credit_nx;
      r_tcnt        <= w_tcnt_nx;
      r_vend_req    <= w_vend_req_nx;
      r_vend_id     <= w_vend_id_nx;
      r_change_req  <= w_change_req_nx;
      r_coin_reject <= w_coin_reject_nx;
      r_sel_nak     <= w_sel_nak_nx;
      r_busy        <= w_busy_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx       = r_state;
    w_credit_nx      = r_credit;
    w_tcnt_nx        = r_tcnt;
    w_vend_req_nx    = r_vend_req;
    w_vend_id_nx     = r_vend_id;
    w_coin_reject_nx = 1'b0;
    w_sel_nak_nx     = 1'b0;
    w_coin           = coin_valid && (coin_in != 2'b00);
    w_sum            = {1'b0, r_credit} + {3'b000, coin_in};

    case (sel_id)
      2'd0:    w_price = CW'(PRICE0);
      2'd1:    w_price = CW'(PRICE1);
      2'd2:    w_price = CW'(PRICE2);
      default: w_price = CW'(PRICE3);
    endcase

    case (r_state)
      S_IDLE: begin
        if (w_coin) begin
          w_credit_nx = {2'b00, coin_in};
          w_tcnt_nx   = '0;
          w_state_nx  = S_CREDIT;
        end
        w_sel_nak_nx = sel_valid;
      end
      S_CREDIT: begin
        // Strobe priority: cancel over selection over coin; a losing coin is returned
        if (cancel) begin
          w_state_nx       = S_CHANGE;
          w_tcnt_nx        = '0;
          w_coin_reject_nx = w_coin;
        end else if (sel_valid) begin
          w_coin_reject_nx = w_coin;
          if (r_credit >= w_price) begin
            w_credit_nx   = r_credit - w_price;
            w_vend_id_nx  = sel_id;
            w_vend_req_nx = 1'b1;
            w_tcnt_nx     = '0;
            w_state_nx    = S_VEND;
          end else begin
            w_sel_nak_nx = 1'b1;
            w_tcnt_nx    = '0;
          end
        end else if (w_coin) begin
          if (w_sum <= (CW+1)'(MAX_CREDIT)) begin
            w_credit_nx = w_sum[CW-1:0];
            w_tcnt_nx   = '0;
          end else begin
            w_coin_reject_nx = 1'b1;
          end
        end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          w_state_nx = S_CHANGE;
          w_tcnt_nx  = '0;
        end else begin
          w_tcnt_nx = r_tcnt + TW'(1);
        end
      end
      S_VEND: begin
        w_coin_reject_nx = w_coin;
        w_sel_nak_nx     = sel_valid;
        if (vend_ack) begin
          w_vend_req_nx = 1'b0;
          w_tcnt_nx     = '0;
          if (r_credit == '0) begin
            w_state_nx = S_IDLE;
          end else begin
`ifdef MULTI_VEND_EN
            w_state_nx = S_CREDIT;
`else
            w_state_nx = S_CHANGE;
`endif
          end
        end
      end
      default: begin
        w_coin_reject_nx = w_coin;
        w_sel_nak_nx     = sel_valid;
        if (r_credit == '0) begin
          w_state_nx = S_IDLE;
        end else if (change_ack) begin
          w_credit_nx = r_credit - CW'(1);
          if (r_credit == CW'(1)) begin
            w_state_nx = S_IDLE;
          end
        end
      end
    endcase

    w_change_req_nx = (w_state_nx == S_CHANGE) && (w_credit_nx != '0);
    w_busy_nx       = (w_state_nx == S_VEND) || (w_state_nx == S_CHANGE);
  end

  assign vend_req    = r_vend_req;
  assign vend_id     = r_vend_id;
  assign change_req  = r_change_req;
  assign credit      = r_credit;
  assign coin_reject = r_coin_reject;
  assign sel_nak     = r_sel_nak;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vend_sequencer;

  localparam int TO  = 24;
  localparam int MAX = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_in = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic       vend_req;
  logic [1:0] vend_id;
  logic       change_req;
  logic [3:0] credit;
  logic       coin_reject;
  logic       sel_nak;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  vend_sequencer #(
    .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(6),
    .MAX_CREDIT(MAX), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_in(coin_in),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .vend_ack(vend_ack), .change_ack(change_ack),
    .vend_req(vend_req), .vend_id(vend_id), .change_req(change_req),
    .credit(credit), .coin_reject(coin_reject), .sel_nak(sel_nak), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: what the machine is doing and how much money it holds
  localparam int M_IDLE = 0, M_SESSION = 1, M_DISPENSING = 2, M_REFUNDING = 3;
  int prices [4] = '{3, 4, 5, 6};
  int m_mode = M_IDLE;
  int m_money = 0;
  int m_quiet = 0;
  int e_vend_req = 0;
  int e_vend_id = 0;
  int e_reject = 0;
  int e_nak = 0;

  always @(posedge clk) begin
    int v;
    e_reject = 0;
    e_nak    = 0;
    v = coin_valid ? int'(coin_in) : 0;
    if (rst) begin
      m_mode = M_IDLE; m_money = 0; m_quiet = 0; e_vend_req = 0; e_vend_id = 0;
    end else if (m_mode == M_IDLE) begin
      if (v != 0) begin m_money = v; m_mode = M_SESSION; m_quiet = 0; end
      if (sel_valid) e_nak = 1;
    end else if (m_mode == M_SESSION) begin
      if (cancel) begin
        m_mode = M_REFUNDING;
        if (v != 0) e_reject = 1;
      end else if (sel_valid) begin
        if (v != 0) e_reject = 1;
        if (m_money >= prices[sel_id]) begin
          m_money = m_money - prices[sel_id];
          e_vend_req = 1; e_vend_id = int'(sel_id); m_mode = M_DISPENSING;
        end else begin
          e_nak = 1; m_quiet = 0;
        end
      end else if (v != 0) begin
        if (m_money + v <= MAX) begin m_money = m_money + v; m_quiet = 0; end
        else e_reject = 1;
      end else begin
        m_quiet = m_quiet + 1;
        if (m_quiet == TO) m_mode = M_REFUNDING;
      end
    end else begin
      if (v != 0) e_reject = 1;
      if (sel_valid) e_nak = 1;
      if (m_mode == M_DISPENSING) begin
        if (vend_ack) begin
          e_vend_req = 0;
`ifdef MULTI_VEND_EN
          if (m_money > 0) begin m_mode = M_SESSION; m_quiet = 0; end
          else m_mode = M_IDLE;
`else
          m_mode = (m_money > 0) ? M_REFUNDING : M_IDLE;
`endif
        end
      end else if (change_ack && m_money > 0) begin
        m_money = m_money - 1;
        if (m_money == 0) m_mode = M_IDLE;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_model();
    chk("vend_req",    int'(vend_req),    e_vend_req);
    chk("vend_id",     int'(vend_id),     e_vend_id);
    chk("change_req",  int'(change_req),  (m_mode == M_REFUNDING && m_money > 0) ? 1 : 0);
    chk("credit",      int'(credit),      m_money);
    chk("coin_reject", int'(coin_reject), e_reject);
    chk("sel_nak",     int'(sel_nak),     e_nak);
    chk("busy",        int'(busy),        (m_mode == M_DISPENSING || m_mode == M_REFUNDING) ? 1 : 0);
  endtask

  // Drive one cycle of inputs, then check the registered response
  task automatic tick(input int cv = 0, input int ci = 0, input int sv = 0, input int si = 0,
                      input int ca = 0, input int va = 0, input int ka = 0, input int r = 0);
    coin_valid = 1'(cv); coin_in = 2'(ci); sel_valid = 1'(sv); sel_id = 2'(si);
    cancel = 1'(ca); vend_ack = 1'(va); change_ack = 1'(ka); rst = 1'(r);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    bit quiet;
    @(negedge clk);
    tick(.r(1)); tick(.r(1));
    chk("reset_credit", int'(credit), 0);
    chk("reset_outs", int'({vend_req, change_req, coin_reject, sel_nak, busy}), 0);

    // 10 + 5 Rs buys product 0 exactly, no change
    tick(.cv(1), .ci(2)); tick(.cv(1), .ci(1));
    chk("t1_credit3", int'(credit), 3);
    tick(.sv(1), .si(0));
    chk("t1_vend_req", int'(vend_req), 1);
    chk("t1_vend_id", int'(vend_id), 0);
    chk("t1_credit0", int'(credit), 0);
    tick(.va(1));
    chk("t1_done", int'({vend_req, change_req, busy}), 0);

    // 15 + 15 Rs, product 1, two coins of change
    tick(.cv(1), .ci(3)); tick(.cv(1), .ci(3));
    chk("t2_credit6", int'(credit), 6);
    tick(.sv(1), .si(1));
    chk("t2_credit2", int'(credit), 2);
    chk("t2_vend_id", int'(vend_id), 1);
    tick(.va(1));
`ifdef MULTI_VEND_EN
    chk("t2_back_to_credit", int'({change_req, busy}), 0);
    tick(.ca(1));
`endif
    chk("t2_change_req", int'(change_req), 1);
    tick(.ka(1));
    chk("t2_credit1", int'(credit), 1);
    tick(.ka(1));
    chk("t2_idle", int'({change_req, busy, credit}), 0);

    // Insufficient credit, then cancel
    tick(.cv(1), .ci(1)); tick(.sv(1), .si(3));
    chk("t3_nak", int'(sel_nak), 1);
    chk("t3_credit1", int'(credit), 1);
    tick();
    chk("t3_nak_pulse", int'(sel_nak), 0);
    tick(.ca(1));
    chk("t3_refund", int'(change_req), 1);
    tick(.ka(1));
    chk("t3_idle", int'({busy, credit}), 0);

    // Credit ceiling
    tick(.cv(1), .ci(3)); tick(.cv(1), .ci(3)); tick(.cv(1), .ci(3));
    tick(.cv(1), .ci(2));
    chk("t4_reject", int'(coin_reject), 1);
    chk("t4_credit9", int'(credit), 9);
    tick(.cv(1), .ci(1));
    chk("t4_credit10", int'(credit), 10);
    chk("t4_no_reject", int'(coin_reject), 0);
    tick(.ca(1));
    for (int i = 0; i < 10; i++) tick(.ka(1));
    chk("t4_idle", int'(busy), 0);

    // Inactivity refund after TO idle cycles
    tick(.cv(1), .ci(1));
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t5_not_yet", int'(change_req), 0);
    tick();
    chk("t5_timeout", int'(change_req), 1);
    tick(.cv(1), .ci(2));
    chk("t5_reject_in_change", int'(coin_reject), 1);
    tick(.ka(1));

    // Reset during dispense, late ack ignored
    tick(.cv(1), .ci(3)); tick(.sv(1), .si(0));
    chk("t6_vending", int'(vend_req), 1);
    tick(.r(1));
    chk("t6_reset", int'({vend_req, change_req, credit, busy}), 0);
    tick(.va(1));
    chk("t6_late_ack", int'({vend_req, change_req, credit, busy}), 0);

    // Randomized traffic, with quiet bursts long enough to reach the timeout
    for (int b = 0; b < 80; b++) begin
      quiet = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 50; c++) begin
        if (quiet)
          tick(.va(int'($urandom_range(0, 2) == 0)), .ka(int'($urandom_range(0, 1))));
        else
          tick(.cv(int'($urandom_range(0, 3) == 0)), .ci(int'($urandom_range(0, 3))),
               .sv(int'($urandom_range(0, 9) == 0)), .si(int'($urandom_range(0, 3))),
               .ca(int'($urandom_range(0, 24) == 0)), .va(int'($urandom_range(0, 2) == 0)),
               .ka(int'($urandom_range(0, 1))), .r(int'($urandom_range(0, 199) == 0)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
